// File: rtl/pe_operand_feeder_pkg.sv
// pe_operand_feeder_pkg: shared FSM state encoding and timing constants for the PE operand feeder
package pe_operand_feeder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;
  localparam int DRAIN_CYCLES = 3;
  localparam int FRAC_BITS = 8;
endpackage

// File: rtl/pe_operand_feeder_operand_pipe.sv
// pe_operand_feeder_operand_pipe: delays rd_en one cycle to match memory latency (clk, reset, rd_en, mem_data_a/b in; floatA/B zero-gated operands out)
module pe_operand_feeder_operand_pipe
  import pe_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data_a,
  input  logic [DATA_WIDTH-1:0] mem_data_b,
  output logic [DATA_WIDTH-1:0] floatA,
  output logic [DATA_WIDTH-1:0] floatB
);
  logic v1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1     <= 1'b0;
      floatA <= '0;
      floatB <= '0;
    end else begin
      v1     <= rd_en;
      floatA <= v1 ? mem_data_a : '0;
      floatB <= v1 ? mem_data_b : '0;
    end
endmodule

// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: sequences one dot product through a MAC PE (start/len/base_a/base_b in; busy, rd_en, addr_a/b, pe_reset, floatA/B, out_data/out_valid out; out_ready in)
module pe_operand_feeder
  import pe_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] mem_data_a,
  input  logic [DATA_WIDTH-1:0] mem_data_b,
  output logic                  pe_reset,
  output logic [DATA_WIDTH-1:0] floatA,
  output logic [DATA_WIDTH-1:0] floatB,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  state_t state, next;
  logic [LEN_WIDTH-1:0] idx, len_r;
  logic [1:0] dcnt;
  logic issue_last, drain_last;
  assign issue_last = idx == len_r - 1'b1;
  assign drain_last = dcnt == 2'(DRAIN_CYCLES - 1);
  always_comb begin
    next = state;
    next = state == IDLE  ? (start ? (len != '0 ? ISSUE : DRAIN) : IDLE) :
           state == ISSUE ? (issue_last ? DRAIN : ISSUE) :
           state == DRAIN ? (drain_last ? HOLD : DRAIN) :
                            (out_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx       <= '0;
      len_r     <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      pe_reset  <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      busy      <= next != IDLE;
      rd_en     <= next == ISSUE;
      pe_reset  <= !(next == ISSUE || next == DRAIN);
      out_valid <= next == HOLD;
      dcnt      <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        idx    <= '0;
        len_r  <= len;
        addr_a <= base_a;
        addr_b <= base_b;
      end
      if (state == ISSUE) begin
        idx <= idx + 1'b1;
        if (!issue_last) begin
          addr_a <= addr_a + 1'b1;
          addr_b <= addr_b + 1'b1;
        end
      end
      if (state == DRAIN && drain_last) out_data <= pe_result;
    end
  pe_operand_feeder_operand_pipe #(.DATA_WIDTH(DATA_WIDTH)) operand_pipe (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .mem_data_a(mem_data_a),
    .mem_data_b(mem_data_b),
    .floatA    (floatA),
    .floatB    (floatB)
  );
endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb_pe_operand_feeder: directed bench with memory and MAC PE models around pe_operand_feeder
module tb_pe_operand_feeder;
  import pe_operand_feeder_pkg::*;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] base_a = '0;
  logic [AW-1:0] base_b = '0;
  logic busy, rd_en, pe_reset, out_valid;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] mem_data_a = '0;
  logic [DW-1:0] mem_data_b = '0;
  logic [DW-1:0] floatA, floatB, pe_result, out_data;
  logic signed [DW-1:0] mem_a [1024];
  logic signed [DW-1:0] mem_b [1024];
  logic signed [31:0] acc;
  int total = 0;
  int bad = 0;
  int addr_log [$];
  int vc, rdn, prl;
  always #5 clk = ~clk;
  pe_operand_feeder dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_a(base_a), .base_b(base_b),
    .busy(busy), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b), .pe_reset(pe_reset),
    .floatA(floatA), .floatB(floatB), .pe_result(pe_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );
  always @(posedge clk)
    if (rd_en) begin
      mem_data_a <= mem_a[addr_a];
      mem_data_b <= mem_b[addr_b];
    end
  always @(posedge clk or posedge pe_reset)
    if (pe_reset) acc <= '0;
    else acc <= acc + $signed(floatA) * $signed(floatB);
  assign pe_result = acc[FRAC_BITS+DW-1:FRAC_BITS];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int l, input int ba, input int bb, output int v, output int r, output int p);
    len = LW'(l);
    base_a = AW'(ba);
    base_b = AW'(bb);
    start = 1'b1;
    tick();
    start = 1'b0;
    v = -1;
    r = 0;
    p = 0;
    addr_log.delete();
    for (int c = 1; c < 40 && v < 0; c++) begin
      if (rd_en) begin
        r++;
        addr_log.push_back(int'(addr_a));
      end
      if (!pe_reset) p++;
      if (out_valid) v = c;
      else tick();
    end
  endtask
  initial begin
    foreach (mem_a[i]) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = 16'sd256; mem_a[1] = 16'sd512; mem_a[2] = -16'sd256;
    mem_b[100] = 16'sd256; mem_b[101] = 16'sd256; mem_b[102] = 16'sd256;
    mem_a[10] = -16'sd768; mem_b[20] = 16'sd512;
    mem_a[1022] = 16'sd512; mem_a[1023] = -16'sd256;
    for (int i = 200; i < 204; i++) mem_b[i] = 16'sd256;
    mem_a[30] = 16'sd1024; mem_a[31] = 16'sd256; mem_b[40] = 16'sd512; mem_b[41] = 16'sd256;
    mem_a[50] = 16'sd768; mem_b[60] = 16'sd256;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_pe_reset", pe_reset, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_addr_a", addr_a, 0);
    check("rst_floatA", floatA, 0);
    reset = 1'b0;
    tick();
    run(3, 0, 100, vc, rdn, prl);
    check("t1_vcyc", vc, 7);
    check("t1_data", out_data, 512);
    check("t1_rdn", rdn, 3);
    tick();
    check("t1_valid_width", out_valid, 0);
    check("t1_busy_after", busy, 0);
    run(1, 10, 20, vc, rdn, prl);
    check("t2_vcyc", vc, 5);
    check("t2_data", out_data, 16'hFA00);
    check("t2_pe_low_cycles", prl, 4);
    check("t2_pe_reset_hold", pe_reset, 1);
    tick();
    run(0, 5, 5, vc, rdn, prl);
    check("t3_rdn", rdn, 0);
    check("t3_vcyc", vc, 4);
    check("t3_data", out_data, 0);
    tick();
    out_ready = 1'b0;
    run(4, 1022, 200, vc, rdn, prl);
    check("t4_vcyc", vc, 8);
    check("t4_naddr", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("t4_addr0", addr_log[0], 1022);
      check("t4_addr1", addr_log[1], 1023);
      check("t4_addr2", addr_log[2], 0);
      check("t4_addr3", addr_log[3], 1);
    end
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", out_data, 1024);
      check("t4_hold_busy", busy, 1);
      start = 1'b1;
      len = LW'(2);
      tick();
    end
    start = 1'b0;
    check("t4_still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("t4_released_valid", out_valid, 0);
    check("t4_released_busy", busy, 0);
    tick();
    check("t4_no_restart_rd", rd_en, 0);
    check("t4_no_restart_busy", busy, 0);
    run(2, 30, 40, vc, rdn, prl);
    check("t5a_vcyc", vc, 6);
    check("t5a_data", out_data, 2304);
    tick();
    run(1, 50, 60, vc, rdn, prl);
    check("t5b_vcyc", vc, 5);
    check("t5b_data", out_data, 768);
    tick();
    len = LW'(5);
    base_a = '0;
    base_b = AW'(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t6_mid_rd_en", rd_en, 1);
    check("t6_mid_addr", addr_a, 2);
    check("t6_mid_floatA", floatA, 256);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rd_en", rd_en, 0);
    check("t6_rst_addr_a", addr_a, 0);
    check("t6_rst_addr_b", addr_b, 0);
    check("t6_rst_pe_reset", pe_reset, 1);
    check("t6_rst_floatA", floatA, 0);
    check("t6_rst_floatB", floatB, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_out_valid", out_valid, 0);
    reset = 1'b0;
    tick();
    run(2, 30, 40, vc, rdn, prl);
    check("t6_new_vcyc", vc, 6);
    check("t6_new_data", out_data, 2304);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Initiator/driver for the multiply-accumulate processing element. It sequences one dot product of length len.
- Reads operand pairs from two synchronous-read memories (weights, activations) and streams them into the PE's floatA/floatB.
- Controls the PE's clear (pe_reset), waits out the pipeline, then captures the PE's scaled result and presents it on a valid/ready output.
- Sits between the layer controller (start/done) and one PE instance.

Parameters:
- DATA_WIDTH, 16, operand and result width (signed fixed point, 8 fractional bits).
- ADDR_WIDTH, 10, memory address width.
- LEN_WIDTH, 10, width of vector length; max len = 2^LEN_WIDTH-1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- len  in  LEN_WIDTH  number of operand pairs; latched on accept.
- base_a  in  ADDR_WIDTH  start address, memory A; latched on accept.
- base_b  in  ADDR_WIDTH  start address, memory B; latched on accept.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  memory read strobe (both memories).
- addr_a  out  ADDR_WIDTH  memory A address.
- addr_b  out  ADDR_WIDTH  memory B address.
- mem_data_a  in  DATA_WIDTH  memory A read data, valid the cycle after rd_en.
- mem_data_b  in  DATA_WIDTH  memory B read data, valid the cycle after rd_en.
- pe_reset  out  1  drives the PE's async reset (clear).
- floatA  out  DATA_WIDTH  signed operand to PE.
- floatB  out  DATA_WIDTH  signed operand to PE.
- pe_result  in  DATA_WIDTH  PE result (accumulator>>8, combinational in PE).
- out_data  out  DATA_WIDTH  captured dot-product result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset values: state=IDLE, busy=0, rd_en=0, addr_a=addr_b=0, floatA=floatB=0, pe_reset=1, out_data=0, out_valid=0.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - start=1 with len>0 -> ISSUE, index=0.
  - start=1 with len=0 -> DRAIN directly.
  - start is ignored in all other states.
- ISSUE:
  - rd_en=1, addr_a=base_a+index, addr_b=base_b+index.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - index increments each cycle; after index=len-1 -> DRAIN.
- Operand pipeline:
  - v1 <= rd_en.
  - floatA/floatB <= v1 ? mem_data_a/mem_data_b : 0.
  - Operands are zero whenever no valid pair is present, because the PE accumulates on every unreset clock.
- DRAIN: exactly 3 cycles. On its last cycle, out_data <= pe_result, then -> HOLD.
- HOLD:
  - out_valid=1; out_data stable until out_ready=1.
  - On out_ready=1 -> IDLE, out_valid=0.
  - out_ready may be high the first HOLD cycle (1-cycle handshake).
- pe_reset is registered from next-state: 0 in ISSUE and DRAIN, 1 in IDLE and HOLD.
  - Net effect: the PE starts every job from zero and sees only valid pairs or zeros.
- Timing (start sampled in cycle 0, len=L):
  - ISSUE occupies cycles 1..L.
  - Pair i is on floatA/floatB in cycle i+3.
  - The last pair is on the operands in cycle L+2.
  - Capture happens at the end of cycle L+3.
  - out_valid first high in cycle L+4. For len=0: out_valid in cycle 4 with out_data=0.
- Arithmetic: no computation in the feeder; out_data is pe_result passed through unmodified. Overflow and truncation are owned by the PE.
- Reset mid-operation: immediate return to reset values, including pe_reset=1, which clears the PE. A pending result is discarded.
- busy=1 through HOLD; done is implied by the out_valid/out_ready transfer.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, ISSUE=1, DRAIN=2, HOLD=3);
  - DRAIN_CYCLES=3;
  - FRAC_BITS=8 for benches.
- Sub-module: operand_pipe, the v1 valid bit plus zero-gated operand registers. Keeps the memory-latency adjustment in one place.
- FSM, counters and output register stay in the top.

Test Plan:
- len=3, A=[256,512,-256], B=[256,256,256], real PE attached, out_ready=1 -> out_data=512, out_valid first high 7 cycles after start, one cycle wide.
- len=1, A=[-768], B=[512] -> out_data=-1536 (0xFA00); pe_reset low only cycles 1..4.
- len=0 -> no rd_en pulses, out_valid at cycle 4, out_data=0.
- base_a=1022, len=4 -> addr_a sequence 1022,1023,0,1. out_ready held low 5 cycles -> out_data and out_valid stable, busy=1, start pulses ignored.
- Two back-to-back jobs: second start in the cycle after the first transfer. The second result is independent of the first (pe_reset high between jobs).
- reset asserted mid-ISSUE (index=2 of 5) -> all outputs at reset values asynchronously. A new len=2 job then produces the correct result with no residue.
